// File: rtl/sdram_arbiter_if.sv
// Request/grant/completion bundle between the requesters, sdram_arbiter and the SDRAM controller.
// slave: the arbiter's view; master: the requester/controller side.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 64
) ();
  // Cache side
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_add;
  logic [LINE_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_done;

  // VGA side
  logic              v_req;
  logic [ADDR_W-1:0] v_add;
  logic              v_gnt;
  logic              v_done;

  // Shared read return
  logic [LINE_W-1:0] rdata;

  // Controller side
  logic              m_req;
  logic              m_we;
  logic              m_ref;
  logic [ADDR_W-1:0] m_add;
  logic [LINE_W-1:0] m_wdata;
  logic              m_done;
  logic [LINE_W-1:0] m_rdata;

  logic              ref_overrun;

  modport slave (
    input  c_req, c_we, c_add, c_wdata, v_req, v_add, m_done, m_rdata,
    output c_gnt, c_done, v_gnt, v_done, rdata,
    output m_req, m_we, m_ref, m_add, m_wdata, ref_overrun
  );

  modport master (
    output c_req, c_we, c_add, c_wdata, v_req, v_add, m_done, m_rdata,
    input  c_gnt, c_done, v_gnt, v_done, rdata,
    input  m_req, m_we, m_ref, m_add, m_wdata, ref_overrun
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the cache and the VGA fetcher, with optional
// auto-refresh scheduling enabled by defining SDRAM_ARB_REFRESH_EN.
module sdram_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LINE_W     = 64,
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned VGA_MAX    = 4
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRef   = 2'd1;
  localparam logic [1:0] StCache = 2'd2;
  localparam logic [1:0] StVga   = 2'd3;

  localparam int unsigned         StreakW   = $clog2(VGA_MAX + 2);
  localparam logic [StreakW-1:0]  StreakMax = StreakW'(VGA_MAX);

  logic [1:0]         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               c_gnt_q, c_gnt_d;
  logic               v_gnt_q, v_gnt_d;
  logic               c_done_q, c_done_d;
  logic               v_done_q, v_done_d;
  logic               m_req_q, m_req_d;
  logic               m_ref_q, m_ref_d;
  logic               m_we_q, m_we_d;
  logic [ADDR_W-1:0]  m_add_q, m_add_d;
  logic [LINE_W-1:0]  m_wdata_q, m_wdata_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic               ref_pending_q;
  logic               ref_overrun_q;
  logic               cache_starved;
  logic               pick_vga;
  logic               pick_cache;

  // The cache only overrides VGA once it has watched VGA_MAX grants go by.
  assign cache_starved = bus.c_req && (streak_q == StreakMax);
  assign pick_vga      = bus.v_req && !cache_starved;
  assign pick_cache    = bus.c_req && (!bus.v_req || cache_starved);

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    c_gnt_d   = 1'b0;
    v_gnt_d   = 1'b0;
    c_done_d  = 1'b0;
    v_done_d  = 1'b0;
    m_req_d   = 1'b0;
    m_ref_d   = 1'b0;
    m_we_d    = m_we_q;
    m_add_d   = m_add_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (ref_pending_q) begin
          state_d   = StRef;
          m_ref_d   = 1'b1;
          m_we_d    = 1'b0;
          m_add_d   = '0;
          m_wdata_d = '0;
        end else if (pick_vga) begin
          state_d   = StVga;
          v_gnt_d   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_add_d   = bus.v_add;
          m_wdata_d = '0;
          if (bus.c_req && (streak_q != StreakMax)) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (pick_cache) begin
          state_d   = StCache;
          c_gnt_d   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = bus.c_we;
          m_add_d   = bus.c_add;
          m_wdata_d = bus.c_wdata;
          streak_d  = '0;
        end
      end
      StRef: begin
        if (bus.m_done) begin
          state_d = StIdle;
        end
      end
      StCache: begin
        if (bus.m_done) begin
          state_d  = StIdle;
          c_done_d = 1'b1;
          rdata_d  = bus.m_rdata;
        end
      end
      StVga: begin
        if (bus.m_done) begin
          state_d  = StIdle;
          v_done_d = 1'b1;
          rdata_d  = bus.m_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      c_gnt_q   <= 1'b0;
      v_gnt_q   <= 1'b0;
      c_done_q  <= 1'b0;
      v_done_q  <= 1'b0;
      m_req_q   <= 1'b0;
      m_ref_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_add_q   <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      c_gnt_q   <= c_gnt_d;
      v_gnt_q   <= v_gnt_d;
      c_done_q  <= c_done_d;
      v_done_q  <= v_done_d;
      m_req_q   <= m_req_d;
      m_ref_q   <= m_ref_d;
      m_we_q    <= m_we_d;
      m_add_q   <= m_add_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int unsigned        RefCntW   = $clog2(REF_PERIOD + 1);
  localparam logic [RefCntW-1:0] RefReload = RefCntW'(REF_PERIOD - 1);

  logic [RefCntW-1:0] ref_cnt_q;
  logic               ref_expire;
  logic               ref_enter;

  assign ref_expire = (ref_cnt_q == '0);
  assign ref_enter  = (state_q == StIdle) && ref_pending_q;

  // A fresh expiry wins over the clear so a back-to-back interval is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q     <= RefReload;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
    end else begin
      ref_cnt_q <= ref_expire ? RefReload : ref_cnt_q - 1'b1;
      if (ref_expire) begin
        ref_pending_q <= 1'b1;
      end else if (ref_enter) begin
        ref_pending_q <= 1'b0;
      end
      if (ref_expire && ref_pending_q) begin
        ref_overrun_q <= 1'b1;
      end
    end
  end
`else
  assign ref_pending_q = 1'b0;
  assign ref_overrun_q = 1'b0;
`endif

  assign bus.c_gnt       = c_gnt_q;
  assign bus.v_gnt       = v_gnt_q;
  assign bus.c_done      = c_done_q;
  assign bus.v_done      = v_done_q;
  assign bus.rdata       = rdata_q;
  assign bus.m_req       = m_req_q;
  assign bus.m_ref       = m_ref_q;
  assign bus.m_we        = m_we_q;
  assign bus.m_add       = m_add_q;
  assign bus.m_wdata     = m_wdata_q;
  assign bus.ref_overrun = ref_overrun_q;

  a_one_grant: assert property (@(posedge clk) disable iff (rst)
    !(c_gnt_q && v_gnt_q) && !(m_ref_q && m_req_q));
  a_cmd_busy: assert property (@(posedge clk) disable iff (rst)
    m_req_q |-> (state_q == StCache || state_q == StVga));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: tests push expected grants/completions, a negedge monitor
// pops and compares them; refresh tests run only when SDRAM_ARB_REFRESH_EN is defined.
module tb_sdram_arbiter;
  localparam int unsigned AW   = 16;
  localparam int unsigned LW   = 64;
  localparam int unsigned VMAX = 4;
`ifdef SDRAM_ARB_REFRESH_EN
  localparam int unsigned RP = 20;
`else
  localparam int unsigned RP = 780;
`endif

  typedef enum logic [1:0] {OwnC, OwnV, OwnR} own_e;
  typedef struct {
    own_e          who;
    logic [AW-1:0] add;
    logic          we;
    logic [LW-1:0] wdata;
  } gnt_t;
  typedef struct {
    own_e          who;
    logic [LW-1:0] data;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  sdram_arbiter #(
    .ADDR_W(AW), .LINE_W(LW), .REF_PERIOD(RP), .VGA_MAX(VMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  gnt_t  exp_gnt[$];
  done_t exp_done[$];
  int    checks = 0;
  int    errors = 0;
  int    ref_seen = 0;

  // Controller model state
  bit            mem_auto = 1'b0;
  int            mem_lat = 2;
  int            mem_cnt = 0;
  own_e          mem_own = OwnC;
  logic [LW-1:0] mem_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_gnt(input own_e who, input logic [AW-1:0] add, input logic we,
                          input logic [LW-1:0] wdata);
    exp_gnt.push_back('{who: who, add: add, we: we, wdata: wdata});
  endtask

  // Monitor: every grant and completion must match the front of its queue.
  always @(negedge clk) begin
    gnt_t  g;
    done_t d;
    own_e  who;
    if (rst === 1'b0) begin
      if (bus.c_gnt || bus.v_gnt || bus.m_ref) begin
        who = bus.m_ref ? OwnR : (bus.v_gnt ? OwnV : OwnC);
        if (bus.m_ref) ref_seen++;
        chk("gnt_single", 64'(bus.c_gnt) + 64'(bus.v_gnt) + 64'(bus.m_ref), 64'd1);
        if (exp_gnt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got owner %0d, required no grant", who);
        end else begin
          g = exp_gnt.pop_front();
          chk("gnt_owner", 64'(who), 64'(g.who));
          chk("gnt_m_req", 64'(bus.m_req), 64'(who != OwnR));
          if (who != OwnR) begin
            chk("gnt_m_add", 64'(bus.m_add), 64'(g.add));
            chk("gnt_m_we", 64'(bus.m_we), 64'(g.we));
            if (g.we) chk("gnt_m_wdata", bus.m_wdata, g.wdata);
          end else begin
            chk("ref_m_we", 64'(bus.m_we), 64'd0);
          end
        end
      end else if (bus.m_req) begin
        checks++;
        errors++;
        $display("FAIL stray_m_req: got m_req without grant, required none");
      end
      if (bus.c_done || bus.v_done) begin
        who = bus.v_done ? OwnV : OwnC;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got owner %0d, required no completion", who);
        end else begin
          d = exp_done.pop_front();
          chk("done_owner", 64'(who), 64'(d.who));
          chk("done_rdata", bus.rdata, d.data);
        end
      end
    end
  end

  // One cycle; inputs change #1 after the edge. In auto mode also acts as the controller.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_auto) begin
      bus.m_done = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.m_done  = 1'b1;
          bus.m_rdata = mem_data;
          if (mem_own != OwnR) exp_done.push_back('{who: mem_own, data: mem_data});
          mem_data = mem_data + 64'h1;
        end
      end
      if (bus.m_req || bus.m_ref) begin
        mem_cnt = mem_lat;
        mem_own = bus.m_ref ? OwnR : (bus.v_gnt ? OwnV : OwnC);
      end
    end
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return bus.c_gnt;
      1:       return bus.v_gnt;
      2:       return bus.c_done;
      3:       return bus.v_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step();
      seen = probe(which);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got timeout after %0d cycles, required event", name, maxc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_flags"}, 64'({bus.c_gnt, bus.c_done, bus.v_gnt, bus.v_done, bus.m_req,
                               bus.m_we, bus.m_ref, bus.ref_overrun}), 64'h0);
    chk({name, "_m_add"}, 64'(bus.m_add), 64'h0);
    chk({name, "_m_wdata"}, bus.m_wdata, 64'h0);
    chk({name, "_rdata"}, bus.rdata, 64'h0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.c_req   = 1'b0;
    bus.v_req   = 1'b0;
    bus.m_done  = 1'b0;
    mem_cnt     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) step();
    chk({name, "_gnt_left"}, 64'(exp_gnt.size()), 64'd0);
    chk({name, "_done_left"}, 64'(exp_done.size()), 64'd0);
    exp_gnt.delete();
    exp_done.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    int cat;
    int cg;
    rst         = 1'b0;
    bus.c_req   = 1'b0;
    bus.c_we    = 1'b0;
    bus.c_add   = '0;
    bus.c_wdata = '0;
    bus.v_req   = 1'b0;
    bus.v_add   = '0;
    bus.m_done  = 1'b0;
    bus.m_rdata = '0;

    // Reset state, checked while reset is asserted.
    #2 rst = 1'b1;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single cache read.
    mem_auto = 1'b1;
    mem_lat  = 3;
    mem_data = 64'hDEAD_BEEF_0123_4567;
    push_gnt(OwnC, 16'h0040, 1'b0, 64'h0);
    bus.c_req = 1'b1;
    bus.c_we  = 1'b0;
    bus.c_add = 16'h0040;
    step();
    chk("read_gnt_latency", 64'({bus.c_gnt, bus.m_req}), 64'h3);
    bus.c_req = 1'b0;
    wait_for("read_done", 2, 20);
    chk("read_rdata", bus.rdata, 64'hDEAD_BEEF_0123_4567);
    drain("read");

    // Write path: m_wdata must hold while the requester changes its inputs.
    do_reset();
    mem_lat  = 6;
    mem_data = 64'h7777_0000_0000_0001;
    push_gnt(OwnC, 16'h1234, 1'b1, 64'h1111_2222_3333_4444);
    bus.c_we    = 1'b1;
    bus.c_add   = 16'h1234;
    bus.c_wdata = 64'h1111_2222_3333_4444;
    bus.c_req   = 1'b1;
    wait_for("write_gnt", 0, 10);
    bus.c_req   = 1'b0;
    bus.c_wdata = 64'h9999_9999_9999_9999;
    bus.c_add   = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.c_done) break;
      chk("write_hold_wdata", bus.m_wdata, 64'h1111_2222_3333_4444);
      chk("write_hold_we", 64'(bus.m_we), 64'd1);
      chk("write_hold_add", 64'(bus.m_add), 64'h1234);
    end
    bus.c_we = 1'b0;
    drain("write");

    // Reset mid-transaction, with rdata still holding the write-test line.
    mem_auto = 1'b0;
    push_gnt(OwnC, 16'h0400, 1'b0, 64'h0);
    bus.c_add = 16'h0400;
    bus.c_req = 1'b1;
    wait_for("rst_mid_gnt", 0, 10);
    bus.c_req = 1'b0;
    repeat (3) step();
    #3 rst = 1'b1;
    #1 chk_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.m_done  = 1'b1;
    bus.m_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    bus.m_done = 1'b0;
    chk("rst_mid_no_done", 64'({bus.c_done, bus.m_req}), 64'h0);
    step();
    chk("rst_mid_no_done2", 64'({bus.c_done, bus.c_gnt}), 64'h0);
    push_gnt(OwnC, 16'h0500, 1'b0, 64'h0);
    bus.c_add = 16'h0500;
    bus.c_req = 1'b1;
    step();
    chk("rst_mid_regrant", 64'({bus.c_gnt, bus.m_req}), 64'h3);
    bus.c_req = 1'b0;
    step();
    bus.m_done  = 1'b1;
    bus.m_rdata = 64'h0123_4567_89AB_CDEF;
    exp_done.push_back('{who: OwnC, data: 64'h0123_4567_89AB_CDEF});
    step();
    bus.m_done = 1'b0;
    chk("rst_mid_done", 64'(bus.c_done), 64'd1);
    chk("rst_mid_rdata", bus.rdata, 64'h0123_4567_89AB_CDEF);
    drain("rst_mid");
    mem_auto = 1'b1;

`ifdef SDRAM_ARB_REFRESH_EN
    // Refresh preemption: expiry during a long VGA fetch, cache waiting.
    do_reset();
    mem_lat  = 25;
    mem_data = 64'hA5A5_0000_0000_0000;
    push_gnt(OwnV, 16'hA000, 1'b0, 64'h0);
    push_gnt(OwnR, 16'h0000, 1'b0, 64'h0);
    push_gnt(OwnC, 16'h00E0, 1'b0, 64'h0);
    ref_seen  = 0;
    bus.c_add = 16'h00E0;
    bus.c_req = 1'b1;
    bus.v_add = 16'hA000;
    bus.v_req = 1'b1;
    cg = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (bus.v_gnt) begin
        bus.v_req = 1'b0;
        mem_lat   = 2;
      end
      if (bus.c_gnt) begin
        bus.c_req = 1'b0;
        cg++;
        chk("pre_ref_before_cache", 64'(ref_seen), 64'd1);
      end
      if (bus.c_done) break;
    end
    chk("pre_cache_granted", 64'(cg), 64'd1);
    chk("pre_overrun", 64'(bus.ref_overrun), 64'd0);
    drain("pre");

    // Refresh overrun: completion withheld for 45 cycles.
    do_reset();
    mem_lat  = 45;
    mem_data = 64'h0F0F_0000_0000_0000;
    push_gnt(OwnC, 16'h00F0, 1'b0, 64'h0);
    push_gnt(OwnR, 16'h0000, 1'b0, 64'h0);
    push_gnt(OwnV, 16'hB000, 1'b0, 64'h0);
    bus.c_add = 16'h00F0;
    bus.c_req = 1'b1;
    wait_for("ovr_gnt", 0, 5);
    bus.c_req = 1'b0;
    mem_lat   = 2;
    chk("ovr_clear_early", 64'(bus.ref_overrun), 64'd0);
    wait_for("ovr_cdone", 2, 60);
    chk("ovr_set", 64'(bus.ref_overrun), 64'd1);
    bus.v_add = 16'hB000;
    bus.v_req = 1'b1;
    wait_for("ovr_vgnt", 1, 12);
    bus.v_req = 1'b0;
    wait_for("ovr_vdone", 3, 12);
    chk("ovr_sticky", 64'(bus.ref_overrun), 64'd1);
    drain("ovr");
`else
    // Starvation: cache held high, VGA re-requesting after each completion.
    do_reset();
    mem_lat  = 2;
    mem_data = 64'h5000;
    push_gnt(OwnV, 16'h8000, 1'b0, 64'h0);
    push_gnt(OwnV, 16'h8001, 1'b0, 64'h0);
    push_gnt(OwnV, 16'h8002, 1'b0, 64'h0);
    push_gnt(OwnV, 16'h8003, 1'b0, 64'h0);
    push_gnt(OwnC, 16'h00C0, 1'b0, 64'h0);
    push_gnt(OwnV, 16'h8004, 1'b0, 64'h0);
    bus.c_we  = 1'b0;
    bus.c_add = 16'h00C0;
    bus.c_req = 1'b1;
    bus.v_add = 16'h8000;
    bus.v_req = 1'b1;
    vcnt = 0;
    cat  = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.v_gnt) begin
        bus.v_req = 1'b0;
        vcnt++;
      end
      if (bus.c_gnt) begin
        bus.c_req = 1'b0;
        cat = vcnt;
      end
      if (bus.v_done) begin
        if (vcnt < 5) begin
          bus.v_req = 1'b1;
          bus.v_add = 16'h8000 + 16'(vcnt);
        end else begin
          break;
        end
      end
    end
    chk("starve_vga_grants", 64'(vcnt), 64'd5);
    chk("starve_cache_slot", 64'(cat), 64'd4);
    drain("starve");

    // VGA only: ten fetches, no cache grant.
    do_reset();
    mem_data = 64'h9000;
    for (int i = 0; i < 10; i++) push_gnt(OwnV, 16'h9000 + 16'(i), 1'b0, 64'h0);
    bus.v_add = 16'h9000;
    bus.v_req = 1'b1;
    vcnt = 0;
    cg   = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (bus.v_gnt) begin
        bus.v_req = 1'b0;
        vcnt++;
      end
      if (bus.c_gnt) cg++;
      if (bus.v_done) begin
        if (vcnt < 10) begin
          bus.v_req = 1'b1;
          bus.v_add = 16'h9000 + 16'(vcnt);
        end else begin
          break;
        end
      end
    end
    chk("vga_only_grants", 64'(vcnt), 64'd10);
    chk("vga_only_cache", 64'(cg), 64'd0);
    drain("vga_only");

    // Refresh disabled: no refresh command over 2000 cycles.
    do_reset();
    ref_seen = 0;
    repeat (2000) step();
    chk("no_ref_pulses", 64'(ref_seen), 64'd0);
    chk("no_ref_overrun", 64'(bus.ref_overrun), 64'd0);
    drain("no_ref");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
